// File: rtl/touch_event_filter_if.sv
// Wishbone B3 slave bundle for the touch event queue.
interface touch_event_filter_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/touch_event_filter.sv
// Touch sample filter: settle discard, box averaging, PRESS/MOVE/RELEASE
// classification and a Wishbone-readable event FIFO with level interrupt.
module touch_event_filter #(
  parameter int DISCARD        = 2,
  parameter int AVG_LOG2       = 2,
  parameter int MOVE_THRESH    = 8,
  parameter int RELEASE_CYCLES = 500_000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  input  logic                 iTOUCH_IRQ,
  input  logic [11:0]          iX_COORD,
  input  logic [11:0]          iY_COORD,
  input  logic                 iTOUCH,
  touch_event_filter_if.slave  wb,
  output logic                 oIRQ,
  output logic                 oPEN
);

  localparam int ACC_W  = 12 + AVG_LOG2;
  localparam int AVG_N  = 1 << AVG_LOG2;
  localparam int SAMP_W = AVG_LOG2 + 1;
  localparam int DISC_W = $clog2(DISCARD + 2);
  localparam int REL_W  = $clog2(RELEASE_CYCLES + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_MOVE    = 2'b10;
  localparam logic [1:0] EV_RELEASE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLE   = 2'd1,
    S_ACCUM    = 2'd2,
    S_REL_WAIT = 2'd3
  } state_t;

  typedef logic [25:0] ev_t;

  function automatic ev_t make_event(input logic [1:0] kind, input logic [11:0] x,
                                     input logic [11:0] y);
    return {kind, x, y};
  endfunction

  function automatic logic [12:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[12] ? (~d + 13'd1) : d;
  endfunction

  state_t              state_q, state_d;
  logic [DISC_W-1:0]   disc_q, disc_d;
  logic [SAMP_W-1:0]   samp_q, samp_d;
  logic [ACC_W-1:0]    acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [REL_W-1:0]    rel_q, rel_d;
  logic                pressed_q, pressed_d;
  logic [11:0]         last_x_q, last_x_d, last_y_q, last_y_d;
  logic                ev_valid_q, ev_valid_d;
  ev_t                 ev_data_q, ev_data_d;
  ev_t                 fifo_q [FIFO_DEPTH];
  ev_t                 fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                irq_en_q, irq_en_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_o_q, dat_o_d;
  logic                pop_pend_q, pop_pend_d;
  logic                ctrl_pend_q, ctrl_pend_d;
  logic [2:0]          ctrl_bits_q, ctrl_bits_d;
  logic                irq_q, irq_d;
  logic                pen_q, pen_d;

  logic [ACC_W-1:0]    sum_x_s, sum_y_s;
  logic [11:0]         avg_x_s, avg_y_s;
  logic                move_s;
  logic                req_s, do_pop_s, flush_s, full_s, push_ok_s;
  logic                unused_s;

  assign unused_s = ^{wb.wb_dat_i[31:3], wb.wb_adr_i[1:0]};

  assign sum_x_s = acc_x_q + ACC_W'(iX_COORD);
  assign sum_y_s = acc_y_q + ACC_W'(iY_COORD);
  assign avg_x_s = 12'(sum_x_s >> AVG_LOG2);
  assign avg_y_s = 12'(sum_y_s >> AVG_LOG2);
  assign move_s  = (abs_diff(avg_x_s, last_x_q) > 13'(MOVE_THRESH)) ||
                   (abs_diff(avg_y_s, last_y_q) > 13'(MOVE_THRESH));

  // Next-state logic: touch FSM, event classifier, FIFO and bus slave.
  always_comb begin
    state_d     = state_q;
    disc_d      = disc_q;
    samp_d      = samp_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    rel_d       = rel_q;
    pressed_d   = pressed_q;
    last_x_d    = last_x_q;
    last_y_d    = last_y_q;
    ev_valid_d  = 1'b0;
    ev_data_d   = ev_data_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    irq_en_d    = irq_en_q;
    dat_o_d     = dat_o_q;
    pop_pend_d  = 1'b0;
    ctrl_pend_d = 1'b0;
    ctrl_bits_d = ctrl_bits_q;
    push_ok_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iTOUCH) begin
          state_d = S_SETTLE;
          disc_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE, S_ACCUM: begin
        if (!iTOUCH) begin
          // Pen lifted: partial average is thrown away.
          state_d = S_REL_WAIT;
          rel_d   = '0;
          acc_x_d = '0;
          acc_y_d = '0;
          samp_d  = '0;
        end else if (iTOUCH_IRQ && (state_q == S_SETTLE)) begin
          if (32'(disc_q) + 32'd1 >= 32'(DISCARD)) begin
            state_d = S_ACCUM;
            disc_d  = '0;
            acc_x_d = '0;
            acc_y_d = '0;
            samp_d  = '0;
          end else begin
            disc_d = disc_q + DISC_W'(1);
          end
        end else if (iTOUCH_IRQ) begin
          if (samp_q == SAMP_W'(AVG_N - 1)) begin
            acc_x_d = '0;
            acc_y_d = '0;
            samp_d  = '0;
            if (!pressed_q) begin
              ev_valid_d = 1'b1;
              ev_data_d  = make_event(EV_PRESS, avg_x_s, avg_y_s);
              pressed_d  = 1'b1;
              last_x_d   = avg_x_s;
              last_y_d   = avg_y_s;
            end else if (move_s) begin
              ev_valid_d = 1'b1;
              ev_data_d  = make_event(EV_MOVE, avg_x_s, avg_y_s);
              last_x_d   = avg_x_s;
              last_y_d   = avg_y_s;
            end else begin
              ev_valid_d = 1'b0;
            end
          end else begin
            acc_x_d = sum_x_s;
            acc_y_d = sum_y_s;
            samp_d  = samp_q + SAMP_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      S_REL_WAIT: begin
        if (iTOUCH) begin
          state_d = S_SETTLE;
          disc_d  = '0;
        end else if (32'(rel_q) + 32'd1 >= 32'(RELEASE_CYCLES)) begin
          state_d    = S_IDLE;
          rel_d      = '0;
          pressed_d  = 1'b0;
          ev_valid_d = pressed_q;
          ev_data_d  = make_event(EV_RELEASE, last_x_q, last_y_q);
        end else begin
          rel_d = rel_q + REL_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read data is captured at the request; pops and CTRL writes commit on ack.
    req_s = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    ack_d = req_s;
    if (req_s && !wb.wb_we_i) begin
      case (wb.wb_adr_i[3:2])
        2'd0: dat_o_d = {15'd0, irq_en_q, 6'd0, pressed_q, overflow_q, 4'd0, 4'(count_q)};
        2'd1: begin
          if (count_q != '0) begin
            dat_o_d    = {6'd0, fifo_q[rd_ptr_q]};
            pop_pend_d = 1'b1;
          end else begin
            dat_o_d = 32'd0;
          end
        end
        2'd2:    dat_o_d = {31'd0, irq_en_q};
        default: dat_o_d = 32'd0;
      endcase
    end else if (req_s) begin
      dat_o_d     = 32'd0;
      ctrl_pend_d = (wb.wb_adr_i[3:2] == 2'd2);
      ctrl_bits_d = wb.wb_dat_i[2:0];
    end else begin
      dat_o_d = dat_o_q;
    end

    do_pop_s = ack_q & pop_pend_q;
    flush_s  = ack_q & ctrl_pend_q & ctrl_bits_q[2];
    full_s   = (count_q == CNT_W'(FIFO_DEPTH));

    if (ack_q && ctrl_pend_q) begin
      irq_en_d = ctrl_bits_q[0];
      if (ctrl_bits_q[1]) begin
        overflow_d = 1'b0;
      end else begin
        overflow_d = overflow_q;
      end
    end else begin
      irq_en_d = irq_en_q;
    end

    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      push_ok_s = ev_valid_q & (~full_s | do_pop_s);
      if (ev_valid_q && full_s && !do_pop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_d;
      end
      if (push_ok_s) begin
        fifo_d[wr_ptr_q] = ev_data_q;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(do_pop_s);
    end

    irq_d = irq_en_d & (count_d != '0);
    pen_d = pressed_d;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q     <= S_IDLE;
      disc_q      <= '0;
      samp_q      <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      rel_q       <= '0;
      pressed_q   <= 1'b0;
      last_x_q    <= 12'd0;
      last_y_q    <= 12'd0;
      ev_valid_q  <= 1'b0;
      ev_data_q   <= '0;
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      irq_en_q    <= 1'b0;
      ack_q       <= 1'b0;
      dat_o_q     <= 32'd0;
      pop_pend_q  <= 1'b0;
      ctrl_pend_q <= 1'b0;
      ctrl_bits_q <= 3'd0;
      irq_q       <= 1'b0;
      pen_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      disc_q      <= disc_d;
      samp_q      <= samp_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      rel_q       <= rel_d;
      pressed_q   <= pressed_d;
      last_x_q    <= last_x_d;
      last_y_q    <= last_y_d;
      ev_valid_q  <= ev_valid_d;
      ev_data_q   <= ev_data_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      irq_en_q    <= irq_en_d;
      ack_q       <= ack_d;
      dat_o_q     <= dat_o_d;
      pop_pend_q  <= pop_pend_d;
      ctrl_pend_q <= ctrl_pend_d;
      ctrl_bits_q <= ctrl_bits_d;
      irq_q       <= irq_d;
      pen_q       <= pen_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_o_q;
  assign oIRQ        = irq_q;
  assign oPEN        = pen_q;

endmodule

// File: tb/tb_touch_event_filter.sv
// Bench for touch_event_filter: event-level reference model checked every cycle
// plus directed reads with hand-computed event words.
module tb_touch_event_filter;
  localparam int RC    = 200;
  localparam int DISC  = 2;
  localparam int AVGL  = 2;
  localparam int THR   = 8;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n, t_irq, touch;
  logic [11:0] tx, ty;
  logic        oIRQ, oPEN;
  logic [31:0] d;

  touch_event_filter_if wb_if ();

  touch_event_filter #(
    .DISCARD(DISC), .AVG_LOG2(AVGL), .MOVE_THRESH(THR),
    .RELEASE_CYCLES(RC), .FIFO_DEPTH(DEPTH)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iTOUCH_IRQ(t_irq), .iX_COORD(tx), .iY_COORD(ty),
    .iTOUCH(touch), .wb(wb_if), .oIRQ(oIRQ), .oPEN(oPEN)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ev_word(input int kind, input int x, input int y);
    return 32'((kind << 24) | (x << 12) | y);
  endfunction

  // ---------------- reference model (event-level) ----------------
  localparam int M_IDLE = 0, M_SETTLE = 1, M_ACCUM = 2, M_REL = 3;
  int          m_mode, m_disc, m_rel, m_lx, m_ly;
  int          sx[$];
  int          sy[$];
  logic [31:0] m_fifo[$];
  bit          m_pressed, m_ovf, m_irq_en, m_ack, m_pop_pend, m_ctrl_pend, m_exp_read;
  bit          m_stage_v, m_new_stage_v;
  logic [31:0] m_stage, m_new_stage, m_exp_dat;
  logic [2:0]  m_ctrl;
  logic        c_rst, c_irq, c_touch, c_cyc, c_stb, c_we;
  logic [3:0]  c_adr;
  logic [31:0] c_dat;
  logic [11:0] c_x, c_y;
  bit          req, was_ack, pop, flush, full, pop_next, ctrl_next;
  int          ax, ay, dx, dy;

  task automatic model_reset();
    m_mode = M_IDLE; m_disc = 0; m_rel = 0; m_lx = 0; m_ly = 0;
    sx.delete(); sy.delete(); m_fifo.delete();
    m_pressed = 0; m_ovf = 0; m_irq_en = 0; m_ack = 0;
    m_pop_pend = 0; m_ctrl_pend = 0; m_exp_read = 0; m_stage_v = 0;
    m_stage = 32'd0; m_exp_dat = 32'd0; m_ctrl = 3'd0;
  endtask

  task automatic emit(input int kind, input int x, input int y);
    m_new_stage_v = 1;
    m_new_stage   = ev_word(kind, x, y);
  endtask

  task automatic model_step();
    if (!c_rst) begin
      model_reset();
      return;
    end
    was_ack   = m_ack;
    req       = c_cyc && c_stb && !m_ack;
    pop_next  = 0;
    ctrl_next = 0;
    if (req) begin
      m_exp_read = !c_we;
      m_exp_dat  = 32'd0;
      if (!c_we) begin
        case (c_adr[3:2])
          2'd0: m_exp_dat = 32'(m_fifo.size()) | (32'(m_ovf) << 8) |
                            (32'(m_pressed) << 9) | (32'(m_irq_en) << 16);
          2'd1: if (m_fifo.size() != 0) begin m_exp_dat = m_fifo[0]; pop_next = 1; end
          2'd2: m_exp_dat = 32'(m_irq_en);
          default: m_exp_dat = 32'd0;
        endcase
      end else if (c_adr[3:2] == 2'd2) begin
        ctrl_next = 1;
      end
    end
    pop   = was_ack && m_pop_pend;
    flush = was_ack && m_ctrl_pend && m_ctrl[2];
    if (was_ack && m_ctrl_pend) begin
      m_irq_en = m_ctrl[0];
      if (m_ctrl[1]) m_ovf = 0;
    end
    if (flush) begin
      m_fifo.delete();
    end else begin
      full = (m_fifo.size() == DEPTH);
      if (pop) void'(m_fifo.pop_front());
      if (m_stage_v) begin
        if (full && !pop) m_ovf = 1;
        else m_fifo.push_back(m_stage);
      end
    end
    // Touch behaviour: events appear in the FIFO one cycle after they are decided.
    m_new_stage_v = 0;
    m_new_stage   = 32'd0;
    if (m_mode == M_IDLE) begin
      if (c_touch) begin m_mode = M_SETTLE; m_disc = 0; end
    end else if (m_mode == M_REL) begin
      if (c_touch) begin
        m_mode = M_SETTLE; m_disc = 0;
      end else begin
        m_rel++;
        if (m_rel == RC) begin
          if (m_pressed) emit(3, m_lx, m_ly);
          m_pressed = 0;
          m_mode = M_IDLE;
        end
      end
    end else if (!c_touch) begin
      m_mode = M_REL; m_rel = 0; sx.delete(); sy.delete();
    end else if (c_irq && m_mode == M_SETTLE) begin
      m_disc++;
      if (m_disc >= DISC) begin m_mode = M_ACCUM; sx.delete(); sy.delete(); end
    end else if (c_irq) begin
      sx.push_back(int'(c_x));
      sy.push_back(int'(c_y));
      if (sx.size() == (1 << AVGL)) begin
        ax = 0; ay = 0;
        foreach (sx[i]) ax += sx[i];
        foreach (sy[i]) ay += sy[i];
        ax = ax / (1 << AVGL);
        ay = ay / (1 << AVGL);
        dx = (ax > m_lx) ? ax - m_lx : m_lx - ax;
        dy = (ay > m_ly) ? ay - m_ly : m_ly - ay;
        if (!m_pressed) begin
          emit(1, ax, ay); m_pressed = 1; m_lx = ax; m_ly = ay;
        end else if (dx > THR || dy > THR) begin
          emit(2, ax, ay); m_lx = ax; m_ly = ay;
        end
        sx.delete(); sy.delete();
      end
    end
    m_stage_v   = m_new_stage_v;
    m_stage     = m_new_stage;
    m_ack       = req;
    m_pop_pend  = req && pop_next;
    m_ctrl_pend = req && ctrl_next;
    if (req) m_ctrl = c_dat[2:0];
  endtask

  // Per-cycle compare of every output against the model.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      c_rst = rst_n; c_irq = t_irq; c_touch = touch; c_x = tx; c_y = ty;
      c_cyc = wb_if.wb_cyc_i; c_stb = wb_if.wb_stb_i; c_we = wb_if.wb_we_i;
      c_adr = wb_if.wb_adr_i; c_dat = wb_if.wb_dat_i;
      #1;
      model_step();
      check("oPEN", 32'(oPEN), 32'(m_pressed));
      check("oIRQ", 32'(oIRQ), 32'(m_irq_en && (m_fifo.size() != 0)));
      check("ack", 32'(wb_if.wb_ack_o), 32'(m_ack));
      if (m_ack && m_exp_read) check("rdata", wb_if.wb_dat_o, m_exp_dat);
      if (!c_rst) check("rst_dat_o", wb_if.wb_dat_o, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int x, input int y);
    @(negedge clk);
    t_irq = 1'b1; tx = 12'(x); ty = 12'(y);
    @(negedge clk);
    t_irq = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    bit got;
    @(negedge clk);
    wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = we;
    wb_if.wb_adr_i = adr; wb_if.wb_dat_i = wdat;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = (wb_if.wb_ack_o === 1'b1);
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL wb_timeout: no ack within 8 cycles, expected ack (adr %h)", adr);
    end
    rdat = wb_if.wb_dat_o;
    @(posedge clk);
    #1;
    wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] adr, output logic [31:0] rdat);
    wb_xfer(1'b0, adr, 32'd0, rdat);
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] wdat);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, wdat, dummy);
  endtask

  initial begin
    rst_n = 1'b0; t_irq = 1'b0; touch = 1'b0; tx = 12'd0; ty = 12'd0;
    wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
    wb_if.wb_adr_i = 4'd0; wb_if.wb_dat_i = 32'd0;
    idle(3);
    check("reset_dat_o", wb_if.wb_dat_o, 32'd0);
    check("reset_irq", 32'(oIRQ), 32'd0);
    check("reset_pen", 32'(oPEN), 32'd0);
    rst_n = 1'b1;

    // First press at (100,200).
    touch = 1'b1;
    idle(2);
    repeat (6) pulse(100, 200);
    idle(2);
    wb_read(4'h0, d); check("status_one", d, 32'h0000_0201);
    wb_read(4'h4, d); check("ev_press", d, 32'h0106_40C8);
    wb_read(4'h0, d); check("status_zero", d, 32'h0000_0200);

    // Small drift is filtered, a large one becomes MOVE.
    repeat (4) pulse(104, 200);
    idle(2);
    wb_read(4'h0, d); check("no_move", d, 32'h0000_0200);
    repeat (4) pulse(120, 200);
    idle(2);
    wb_read(4'h4, d); check("ev_move", d, 32'h0207_80C8);

    // Short lift: no event, still pressed.
    touch = 1'b0; idle(100); touch = 1'b1; idle(2);
    wb_read(4'h0, d); check("short_lift", d, 32'h0000_0200);
    check("pen_held", 32'(oPEN), 32'd1);

    // Long lift: RELEASE with last coordinates.
    touch = 1'b0; idle(RC + 6);
    wb_read(4'h4, d); check("ev_release", d, 32'h0307_80C8);
    check("pen_released", 32'(oPEN), 32'd0);

    // New press, truncating average of 100..103.
    touch = 1'b1; idle(2);
    pulse(500, 500); pulse(500, 500);
    for (int i = 0; i < 4; i++) pulse(100 + i, 200);
    idle(2);
    wb_read(4'h4, d); check("ev_press_avg", d, 32'h0106_50C8);

    // Nine MOVEs with no reads: eight kept, overflow sticky.
    for (int k = 0; k < 9; k++) repeat (4) pulse((k % 2 == 0) ? 300 : 100, 200);
    idle(2);
    wb_read(4'h0, d); check("status_full", d, 32'h0000_0308);
    wb_read(4'h4, d); check("ev_first_kept", d, 32'h0212_C0C8);
    wb_read(4'h0, d); check("status_seven", d, 32'h0000_0307);
    wb_write(4'h8, 32'h2);
    wb_read(4'h0, d); check("ovf_cleared", d, 32'h0000_0207);
    wb_write(4'h8, 32'h4);
    wb_read(4'h0, d); check("flushed", d, 32'h0000_0200);

    // Empty read and unmapped register.
    wb_read(4'h4, d); check("ev_empty", d, 32'h0000_0000);
    wb_read(4'h0, d); check("status_after_empty", d, 32'h0000_0200);
    wb_read(4'hC, d); check("reg3", d, 32'h0000_0000);

    // Interrupt: rises with one event, drops the cycle after the popping ack.
    wb_write(4'h8, 32'h1);
    wb_read(4'h8, d); check("ctrl_read", d, 32'h0000_0001);
    repeat (4) pulse(100, 200);
    idle(2);
    check("irq_high", 32'(oIRQ), 32'd1);
    wb_read(4'h4, d); check("ev_irq", d, 32'h0206_40C8);
    check("irq_dropped", 32'(oIRQ), 32'd0);

    // Reset during pen-up wait: no RELEASE afterwards.
    touch = 1'b0; idle(50);
    rst_n = 1'b0; idle(2); rst_n = 1'b1;
    idle(RC + 10);
    wb_read(4'h0, d); check("after_reset", d, 32'h0000_0000);
    check("pen_after_reset", 32'(oPEN), 32'd0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
